// File: rtl/mem_arbiter_pkg.sv
// Shared types for the unified-memory arbiter: FSM states, owner encoding,
// arbitration mode constants and a counter-width helper.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWNER_CORE = 1'b0,
        OWNER_LOAD = 1'b1
    } owner_t;

    localparam logic PRIO_RR    = 1'b0;
    localparam logic PRIO_FIXED = 1'b1;

    // Counter only has to hold ACCESS_CYCLES-1; keep at least one bit.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester handshakes plus the memory-side bus of the arbiter.
// slave = arbiter view, master = requesters/memory view.
interface mem_arbiter_if;

    logic        req0;
    logic        we0;
    logic [31:0] adr0;
    logic [31:0] wd0;
    logic [31:0] rd0;
    logic        ack0;

    logic        req1;
    logic        we1;
    logic [31:0] adr1;
    logic [31:0] wd1;
    logic [31:0] rd1;
    logic        ack1;

    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    modport slave (
        input  req0, we0, adr0, wd0,
        output rd0, ack0,
        input  req1, we1, adr1, wd1,
        output rd1, ack1,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output req0, we0, adr0, wd0,
        input  rd0, ack0,
        output req1, we1, adr1, wd1,
        input  rd1, ack1,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/mem_arbiter_rr_pick2.sv
// Combinational two-way picker: single requester wins outright, ties go to
// port 0 in fixed mode or to the port that did not own the last grant.
module rr_pick2
    import arb_pkg::*;
(
    input  logic   req0,
    input  logic   req1,
    input  owner_t last_owner,
    input  logic   mode,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_owner = OWNER_CORE;
        if (req0 && req1) begin
            if (mode == PRIO_FIXED) begin
                grant_owner = OWNER_CORE;
            end else begin
                grant_owner = (last_owner == OWNER_CORE) ? OWNER_LOAD : OWNER_CORE;
            end
        end else if (req1) begin
            grant_owner = OWNER_LOAD;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the unified instruction/data memory (IDLE/ACCESS/ACK FSM).
// Optional grant/contention statistics are built when ARB_STATS_EN is defined.
module mem_arbiter
    import arb_pkg::*;
#(
    parameter int ACCESS_CYCLES = 1,
    parameter int PRIORITY_MODE = 0,
    parameter int STAT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    mem_arbiter_if.slave      bus,
    output logic              busy,
    output logic [STAT_W-1:0] stat_grant0,
    output logic [STAT_W-1:0] stat_grant1,
    output logic [STAT_W-1:0] stat_contend
);

    localparam int   CNT_W    = cnt_width(ACCESS_CYCLES);
    localparam logic ARB_MODE = (PRIORITY_MODE != 0) ? PRIO_FIXED : PRIO_RR;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ACCESS_CYCLES - 1);

    arb_state_t       state_q, state_d;
    owner_t           owner_q, owner_d;
    owner_t           last_owner_q, last_owner_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      wd_q, wd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rd0_q, rd0_d;
    logic [31:0]      rd1_q, rd1_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;

    logic             grant_valid;
    owner_t           grant_owner;

    rr_pick2 u_pick (
        .req0        (bus.req0),
        .req1        (bus.req1),
        .last_owner  (last_owner_q),
        .mode        (ARB_MODE),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        we_d         = we_q;
        adr_d        = adr_q;
        wd_d         = wd_q;
        cnt_d        = cnt_q;
        rd0_d        = rd0_q;
        rd1_d        = rd1_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    owner_d      = grant_owner;
                    last_owner_d = grant_owner;
                    cnt_d        = CNT_INIT;
                    state_d      = ACCESS;
                    if (grant_owner == OWNER_LOAD) begin
                        we_d  = bus.we1;
                        adr_d = bus.adr1;
                        wd_d  = bus.wd1;
                    end else begin
                        we_d  = bus.we0;
                        adr_d = bus.adr0;
                        wd_d  = bus.wd0;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    // Read data is captured only for reads; writes leave rd untouched.
                    if (owner_q == OWNER_LOAD) begin
                        ack1_d = 1'b1;
                        if (!we_q) rd1_d = bus.mem_rd;
                    end else begin
                        ack0_d = 1'b1;
                        if (!we_q) rd0_d = bus.mem_rd;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= OWNER_CORE;
            last_owner_q <= OWNER_LOAD;
            cnt_q        <= '0;
            rd0_q        <= '0;
            rd1_q        <= '0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            cnt_q        <= cnt_d;
            rd0_q        <= rd0_d;
            rd1_q        <= rd1_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
        end
    end

    // Latched request payload needs no reset: it is only observed in ACCESS.
    always_ff @(posedge clk) begin
        we_q  <= we_d;
        adr_q <= adr_d;
        wd_q  <= wd_d;
    end

    always_comb begin
        bus.mem_we = 1'b0;
        bus.mem_a  = '0;
        bus.mem_wd = '0;
        if (state_q == ACCESS) begin
            bus.mem_a  = adr_q;
            bus.mem_wd = wd_q;
            bus.mem_we = we_q && (cnt_q == '0) && !reset;
        end
    end

    assign bus.rd0  = rd0_q;
    assign bus.rd1  = rd1_q;
    assign bus.ack0 = ack0_q;
    assign bus.ack1 = ack1_q;
    assign busy     = (state_q == ACCESS) || (state_q == ACK);

`ifdef ARB_STATS_EN
    logic [STAT_W-1:0] grant0_q, grant0_d;
    logic [STAT_W-1:0] grant1_q, grant1_d;
    logic [STAT_W-1:0] contend_q, contend_d;
    logic              grant_fire;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

    assign grant_fire = (state_q == IDLE) && grant_valid;

    always_comb begin
        grant0_d  = grant0_q;
        grant1_d  = grant1_q;
        contend_d = contend_q;
        if (grant_fire) begin
            if (grant_owner == OWNER_LOAD) grant1_d = sat_inc(grant1_q);
            else                           grant0_d = sat_inc(grant0_q);
            if (bus.req0 && bus.req1)      contend_d = sat_inc(contend_q);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_q  <= '0;
            grant1_q  <= '0;
            contend_q <= '0;
        end else begin
            grant0_q  <= grant0_d;
            grant1_q  <= grant1_d;
            contend_q <= contend_d;
        end
    end

    assign stat_grant0  = grant0_q;
    assign stat_grant1  = grant1_q;
    assign stat_contend = contend_q;
`else
    assign stat_grant0  = '0;
    assign stat_grant1  = '0;
    assign stat_contend = '0;
`endif

endmodule
